// File: rtl/clkdiv_ctrl.sv
// Programmable clock divider with handshaked run-time divisor/enable updates.
// Updates take effect only at a period boundary, so clock_out has no runt or stretched pulses.
module clkdiv_ctrl #(
   parameter int CNT_W       = 7,
   parameter int DEFAULT_DIV = 10,
   parameter bit RESET_EN    = 1'b1
) (
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic             cfg_en,
   output logic             clock_out,
   output logic [CNT_W-1:0] div_active,
   output logic             busy,
   output logic             period_done,
   output logic             err
);

   typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

   localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] div_q;
   logic [CNT_W-1:0] pdiv_q;
   logic             pen_q;
   logic             clk_q;
   logic             err_q;

   logic xfer;
   logic req_ok;
   logic last;

   assign cfg_ready = (state_q != PEND);
   assign xfer      = cfg_valid && cfg_ready;
   // A disable request never needs a divisor, so it is always legal.
   assign req_ok    = !cfg_en || (cfg_div >= MIN_DIV);
   assign last      = (state_q != IDLE) && (cnt_q == div_q - ONE);

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RESET_EN ? RUN : IDLE;
         cnt_q   <= '0;
         div_q   <= DEF_DIV;
         pdiv_q  <= '0;
         pen_q   <= 1'b0;
         clk_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q <= xfer && !req_ok;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               clk_q <= 1'b0;
               if (xfer && req_ok && cfg_en) begin
                  div_q   <= cfg_div;
                  state_q <= RUN;
               end
            end
            default: begin
               clk_q <= (cnt_q < (div_q >> 1));
               cnt_q <= last ? '0 : cnt_q + ONE;
               if (state_q == RUN) begin
                  if (xfer && req_ok) begin
                     pdiv_q  <= cfg_div;
                     pen_q   <= cfg_en;
                     state_q <= PEND;
                  end
               end else if (last) begin
                  // Boundary: the held-back request finally takes effect.
                  if (pen_q) begin
                     div_q   <= pdiv_q;
                     state_q <= RUN;
                  end else begin
                     clk_q   <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
         endcase
      end
   end

   assign clock_out   = clk_q;
   assign div_active  = div_q;
   assign busy        = (state_q == PEND);
   assign period_done = last;
   assign err         = err_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Bench for clkdiv_ctrl: cycle-by-cycle comparison against a period-arithmetic reference
// model, with directed scenarios plus randomized request traffic.
module tb_clkdiv_ctrl;

   localparam int CW  = 7;
   localparam int DEF = 10;
   localparam logic [CW+4:0] RST_VEC = {5'b00010, 7'(DEF)};

   logic          clock_in = 1'b0;
   logic          reset_n;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [CW-1:0] cfg_div;
   logic          cfg_en;
   logic          clock_out;
   logic [CW-1:0] div_active;
   logic          busy;
   logic          period_done;
   logic          err;
   logic [CW+4:0] obs;

   int checks = 0;
   int errors = 0;

   // Reference model: period phase derived from the cycle at which the current divisor started.
   int cyc, base, m_div, m_pdiv;
   bit m_act, m_pend, m_pen, m_clk, m_err, m_xfer;

   clkdiv_ctrl #(.CNT_W(CW), .DEFAULT_DIV(DEF), .RESET_EN(1'b1)) dut (
      .clock_in(clock_in), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_div(cfg_div), .cfg_en(cfg_en), .clock_out(clock_out), .div_active(div_active),
      .busy(busy), .period_done(period_done), .err(err)
   );

   always #5 clock_in = ~clock_in;

   assign obs = {clock_out, period_done, busy, cfg_ready, err, div_active};

   function automatic int phase();
      return m_act ? (cyc - base) % m_div : 0;
   endfunction

   function automatic logic [CW+4:0] expv();
      logic pd;
      pd = m_act && (phase() == m_div - 1);
      return {m_clk, pd, m_pend, !m_pend, m_err, 7'(m_div)};
   endfunction

   task automatic model_reset();
      cyc = 0; base = 0; m_div = DEF; m_pdiv = 0;
      m_act = 1'b1; m_pend = 1'b0; m_pen = 1'b0; m_clk = 1'b0; m_err = 1'b0; m_xfer = 1'b0;
   endtask

   // Advance one clock: model evaluates pre-edge inputs, outputs are sampled 1 ns after the edge.
   task automatic step();
      int  ph;
      bit  boundary, illegal, nclk;
      ph       = phase();
      boundary = m_act && (ph == m_div - 1);
      m_xfer   = cfg_valid && !m_pend;
      illegal  = cfg_en && (cfg_div < 2);
      @(posedge clock_in);
      cyc++;
      nclk  = m_act && (ph < m_div / 2);
      m_err = m_xfer && illegal;
      if (!m_act) begin
         if (m_xfer && !illegal && cfg_en) begin
            m_act = 1'b1; m_div = int'(cfg_div); base = cyc;
         end
      end else if (!m_pend) begin
         if (m_xfer && !illegal) begin
            m_pend = 1'b1; m_pdiv = int'(cfg_div); m_pen = cfg_en;
         end
      end else if (boundary) begin
         m_pend = 1'b0;
         if (m_pen) begin
            m_div = m_pdiv; base = cyc;
         end else begin
            m_act = 1'b0; nclk = 1'b0;
         end
      end
      m_clk = nclk;
      #1;
   endtask

   task automatic drive(input int d, input bit en);
      cfg_valid = 1'b1;
      cfg_div   = CW'(d);
      cfg_en    = en;
   endtask

   task automatic test_reset();
      reset_n = 1'b1; cfg_valid = 1'b0; cfg_div = '0; cfg_en = 1'b0;
      #1 reset_n = 1'b0;
      #2;
      checks++;
      if (obs !== RST_VEC) begin
         errors++; $display("FAIL reset_values got=%h exp=%h", obs, RST_VEC);
      end
      @(negedge clock_in);
      reset_n = 1'b1;
      model_reset();
      checks++;
      if (obs !== RST_VEC) begin
         errors++; $display("FAIL reset_release got=%h exp=%h", obs, RST_VEC);
      end
   endtask

   task automatic test_default_run();
      int pd_n = 0, hi_n = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         checks++;
         if (obs !== expv()) begin
            errors++; $display("FAIL default_run cyc=%0d got=%h exp=%h", cyc, obs, expv());
         end
         pd_n += int'(period_done);
         hi_n += int'(clock_out);
      end
      checks++;
      if (pd_n !== 3 || hi_n !== 15) begin
         errors++; $display("FAIL default_counts got pd=%0d hi=%0d exp pd=3 hi=15", pd_n, hi_n);
      end
   endtask

   task automatic test_illegal();
      drive(1, 1'b1);
      step();
      cfg_valid = 1'b0;
      checks++;
      if (obs !== expv() || err !== 1'b1) begin
         errors++; $display("FAIL illegal_err cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
      step();
      checks++;
      if (obs !== expv() || err !== 1'b0 || div_active !== 7'd10 || busy !== 1'b0) begin
         errors++; $display("FAIL illegal_after cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
   endtask

   task automatic test_update();
      bit found = 1'b0;
      int run = 0, min_run = 1000, changes = 0;
      logic prev;
      for (int i = 0; i < 20 && !found; i++) begin
         if (phase() == 2) found = 1'b1;
         else begin
            step();
            checks++;
            if (obs !== expv()) begin
               errors++; $display("FAIL update_wait cyc=%0d got=%h exp=%h", cyc, obs, expv());
            end
         end
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL update_timeout got phase=%0d exp 2", phase());
      end
      drive(4, 1'b1);
      step();
      cfg_valid = 1'b0;
      checks++;
      if (obs !== expv() || busy !== 1'b1 || cfg_ready !== 1'b0) begin
         errors++; $display("FAIL update_accept cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
      prev = clock_out;
      for (int i = 0; i < 40; i++) begin
         step();
         checks++;
         if (obs !== expv()) begin
            errors++; $display("FAIL update_run cyc=%0d got=%h exp=%h", cyc, obs, expv());
         end
         run++;
         if (clock_out !== prev) begin
            if (changes > 0 && run < min_run) min_run = run;
            changes++;
            run = 0;
         end
         prev = clock_out;
      end
      checks++;
      if (div_active !== 7'd4 || min_run < 2) begin
         errors++; $display("FAIL update_final got div=%0d min_pulse=%0d exp div=4 min>=2", div_active, min_run);
      end
   endtask

   task automatic test_disable();
      int hi_n = 0;
      bit stopped = 1'b0;
      drive(0, 1'b0);
      step();
      cfg_valid = 1'b0;
      checks++;
      if (obs !== expv() || busy !== 1'b1) begin
         errors++; $display("FAIL disable_accept cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
      for (int i = 0; i < 20 && !stopped; i++) begin
         step();
         checks++;
         if (obs !== expv()) begin
            errors++; $display("FAIL disable_drain cyc=%0d got=%h exp=%h", cyc, obs, expv());
         end
         stopped = !m_act;
      end
      for (int i = 0; i < 3; i++) step();
      checks++;
      if (!stopped || clock_out !== 1'b0 || busy !== 1'b0 || period_done !== 1'b0) begin
         errors++; $display("FAIL disable_idle got clk=%b busy=%b pd=%b exp 0 0 0", clock_out, busy, period_done);
      end
      drive(3, 1'b1);
      step();
      cfg_valid = 1'b0;
      checks++;
      if (obs !== expv() || clock_out !== 1'b0) begin
         errors++; $display("FAIL enable_xfer cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
      step();
      checks++;
      if (obs !== expv() || clock_out !== 1'b1) begin
         errors++; $display("FAIL enable_rise cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
      for (int i = 0; i < 9; i++) begin
         step();
         checks++;
         if (obs !== expv()) begin
            errors++; $display("FAIL enable_run cyc=%0d got=%h exp=%h", cyc, obs, expv());
         end
         hi_n += int'(clock_out);
      end
      checks++;
      if (hi_n !== 3) begin
         errors++; $display("FAIL enable_highs got=%0d exp=3", hi_n);
      end
   endtask

   task automatic test_back_to_back();
      bit acc = 1'b0, done = 1'b0;
      drive(5, 1'b1);
      step();
      checks++;
      if (obs !== expv() || !m_xfer) begin
         errors++; $display("FAIL b2b_first cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
      drive(7, 1'b1);
      for (int i = 0; i < 20 && !acc; i++) begin
         step();
         checks++;
         if (obs !== expv()) begin
            errors++; $display("FAIL b2b_hold cyc=%0d got=%h exp=%h", cyc, obs, expv());
         end
         acc = m_xfer;
      end
      cfg_valid = 1'b0;
      checks++;
      if (!acc || div_active !== 7'd5 || busy !== 1'b1) begin
         errors++; $display("FAIL b2b_second got acc=%b div=%0d busy=%b exp 1 5 1", acc, div_active, busy);
      end
      for (int i = 0; i < 30 && !done; i++) begin
         step();
         checks++;
         if (obs !== expv()) begin
            errors++; $display("FAIL b2b_apply cyc=%0d got=%h exp=%h", cyc, obs, expv());
         end
         done = (m_div == 7);
      end
      checks++;
      if (div_active !== 7'd7) begin
         errors++; $display("FAIL b2b_final got=%0d exp=7", div_active);
      end
   endtask

   task automatic test_max_div();
      bit done = 1'b0;
      int hi_n = 0, pd_n = 0;
      drive((1 << CW) - 1, 1'b1);
      for (int i = 0; i < 40 && !done; i++) begin
         step();
         if (m_xfer) cfg_valid = 1'b0;
         checks++;
         if (obs !== expv()) begin
            errors++; $display("FAIL max_wait cyc=%0d got=%h exp=%h", cyc, obs, expv());
         end
         done = (m_div == (1 << CW) - 1) && !m_pend;
      end
      cfg_valid = 1'b0;
      for (int i = 0; i < 254; i++) begin
         step();
         checks++;
         if (obs !== expv()) begin
            errors++; $display("FAIL max_run cyc=%0d got=%h exp=%h", cyc, obs, expv());
         end
         hi_n += int'(clock_out);
         pd_n += int'(period_done);
      end
      checks++;
      if (!done || hi_n !== 126 || pd_n !== 2) begin
         errors++; $display("FAIL max_counts got hi=%0d pd=%0d exp hi=126 pd=2", hi_n, pd_n);
      end
   endtask

   task automatic test_reset_pend();
      int hi_n = 0;
      reset_n = 1'b0;
      @(negedge clock_in);
      reset_n = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) step();
      drive(4, 1'b1);
      step();
      cfg_valid = 1'b0;
      step();
      step();
      checks++;
      if (obs !== expv() || busy !== 1'b1) begin
         errors++; $display("FAIL rstpend_pend cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (obs !== RST_VEC) begin
         errors++; $display("FAIL rstpend_async got=%h exp=%h", obs, RST_VEC);
      end
      @(negedge clock_in);
      reset_n = 1'b1;
      model_reset();
      for (int i = 0; i < 30; i++) begin
         step();
         checks++;
         if (obs !== expv()) begin
            errors++; $display("FAIL rstpend_run cyc=%0d got=%h exp=%h", cyc, obs, expv());
         end
         if (i < 20) hi_n += int'(clock_out);
      end
      checks++;
      if (div_active !== 7'd10 || hi_n !== 10) begin
         errors++; $display("FAIL rstpend_final got div=%0d hi=%0d exp div=10 hi=10", div_active, hi_n);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         if (!cfg_valid && $urandom_range(0, 7) == 0)
            drive(($urandom_range(0, 9) == 0) ? 127 : int'($urandom_range(0, 12)),
                  $urandom_range(0, 4) != 0);
         step();
         if (m_xfer) cfg_valid = 1'b0;
         checks++;
         if (obs !== expv()) begin
            errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, expv());
         end
      end
   endtask

   initial begin
      test_reset();
      test_default_run();
      test_illegal();
      test_update();
      test_disable();
      test_back_to_back();
      test_max_div();
      test_reset_pend();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
